// File: rtl/html_char_source_pkg.sv
// html_defines: character constants and fetch-state type for the HTML character source.
`ifndef HTML_DEFINES_CHAR_BITES
`define HTML_DEFINES_CHAR_BITES
`define CHAR_BITES 8
`endif
package html_defines;
    localparam logic [`CHAR_BITES-1:0] CHAR_NUL   = 8'h00;
    localparam logic [`CHAR_BITES-1:0] CHAR_SPACE = 8'h20;
    localparam logic [`CHAR_BITES-1:0] CHAR_TAB   = 8'h09;
    localparam logic [`CHAR_BITES-1:0] CHAR_LF    = 8'h0A;
    localparam logic [`CHAR_BITES-1:0] CHAR_CR    = 8'h0D;
    typedef enum logic {FETCH, DONE} fetch_state_t;
    function automatic logic [`CHAR_BITES-1:0] ws_map(input logic [`CHAR_BITES-1:0] c);
        return (c == CHAR_TAB || c == CHAR_LF || c == CHAR_CR) ? CHAR_SPACE : c;
    endfunction
endpackage

// File: rtl/html_char_source_fifo.sv
// char_fifo: power-of-two circular prefetch buffer; dout reads 0 while empty.
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    assign dout = (count != '0) ? mem[rd_ptr] : '0;
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/html_char_source.sv
// html_char_source: prefetches document bytes from a synchronous ROM and serves them one char per next_char.
// Optional WHITESPACE_COLLAPSE_EN maps tab/LF/CR to space and squeezes runs of spaces.
module html_char_source
    import html_defines::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DOC_LENGTH = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   next_char,
    output logic [`CHAR_BITES-1:0] char,
    output logic                   char_valid,
    output logic                   at_end,
    output logic                   underflow,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    output logic                   rom_rd,
    input  logic [`CHAR_BITES-1:0] rom_data
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0] DOC_END = (ADDR_WIDTH+1)'(DOC_LENGTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
    fetch_state_t state, state_d;
    logic [ADDR_WIDTH:0] addr;
    logic [CW-1:0] count, inflight;
    logic [CW:0] used;
    logic ret, issue, pop, push, drop;
    logic [`CHAR_BITES-1:0] byte_in;
    // a pop in this cycle already frees its slot, so the refill can issue alongside it
    assign pop        = enable && next_char && char_valid;
    assign used       = {1'b0, count} + {1'b0, inflight} - (CW+1)'(pop);
    assign issue      = state == FETCH && enable && used < DEPTH_W && addr < DOC_END;
    assign push       = ret && state == FETCH && rom_data != CHAR_NUL && !drop;
    assign char_valid = count != '0;
`ifdef WHITESPACE_COLLAPSE_EN
    logic last_space;
    assign byte_in = ws_map(rom_data);
    assign drop    = last_space && byte_in == CHAR_SPACE;
    always_ff @(posedge clock) begin
        if (reset) last_space <= 1'b0;
        else if (push) last_space <= byte_in == CHAR_SPACE;
    end
`else
    assign byte_in = rom_data;
    assign drop    = 1'b0;
`endif
    always_comb begin
        state_d = state;
        state_d = (state == FETCH && ((ret && rom_data == CHAR_NUL) || (addr == DOC_END && inflight == '0))) ? DONE : state;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FETCH;
            addr      <= '0;
            inflight  <= '0;
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            ret       <= 1'b0;
            at_end    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state    <= state_d;
            ret      <= rom_rd;
            rom_rd   <= issue;
            inflight <= inflight + CW'(issue) - CW'(ret);
            at_end   <= state == DONE && count == '0 && inflight == '0;
            if (issue) begin
                rom_addr <= addr[ADDR_WIDTH-1:0];
                addr     <= addr + (ADDR_WIDTH+1)'(1);
            end
            if (enable && next_char && !char_valid && !at_end) underflow <= 1'b1;
        end
    end
    char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(`CHAR_BITES)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (byte_in),
        .pop   (pop),
        .dout  (char),
        .count (count)
    );
endmodule
